// File: rtl/md_unit_if.sv
// md_unit_if -- E-stage connection between the pipeline and the multiply/divide unit.
//
// Signals (pipeline view):
//   start  [3:0]  decoded MD op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//                 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO (9..15 behave as 0)
//   req           flush of the E-stage instruction; suppresses start this cycle
//   a, b   [31:0] forwarded rs / rt operands
//   busy          operation in flight (for the D-stage hazard stall)
//   hi, lo [31:0] architectural HI/LO
//   rdata  [31:0] MFHI/MFLO read value, zero latency
//
// master = pipeline side, slave = md_unit.
interface md_unit_if;
  logic [3:0]  start;
  logic        req;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  modport master (
    output start, req, a, b,
    input  busy, hi, lo, rdata
  );

  modport slave (
    input  start, req, a, b,
    output busy, hi, lo, rdata
  );
endinterface

// File: rtl/md_unit.sv
// md_unit -- multi-cycle multiply/divide unit for the E stage, owner of HI/LO.
//
// The result of MULT/MULTU/DIV/DIVU is computed in the cycle the op is
// accepted and parked in shadow registers; a down-counter then models the
// architectural latency, and HI/LO take the shadow value when the counter
// reaches its terminal count. MTHI/MTLO write HI/LO directly from idle.
//
// Ports:
//   clk    in   pipeline clock, rising edge
//   reset  in   asynchronous, active-high; clears all state
//   md     slave modport of md_unit_if (start, req, a, b -> busy, hi, lo, rdata)
//
// Parameters:
//   MUL_CYCLES  busy cycles for MULT/MULTU (>= 1)
//   DIV_CYCLES  busy cycles for DIV/DIVU   (>= 1)
//
// Build option:
//   MDU_DIV0_FAST_EN  when defined, DIV/DIVU with b == 0 completes without a
//                     busy period; otherwise it runs the full DIV_CYCLES and
//                     then leaves HI/LO untouched.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no op in flight; accepts MD ops and MTHI/MTLO, busy = 0
// RUN   | mul/div in flight; cnt counts down, commit at cnt == 1
module md_unit #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic       clk,
  input  logic       reset,
  md_unit_if.slave   md
);

  localparam int CW = 16;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [31:0]     hi_q, lo_q;
  logic [31:0]     hi_n, lo_n;
  logic            wr_n;

  logic [3:0]      op;
  logic            is_mul, is_div, div0, div0_skip;
  logic            load, commit, wr_hi, wr_lo;

  logic [63:0]     a_sx, b_sx, a_zx, b_zx;
  logic [63:0]     prod_s, prod_u;
  logic [31:0]     dvs;
  logic            div_ovf;
  logic [31:0]     quot_s, rem_s, quot_u, rem_u;
  logic [31:0]     res_hi, res_lo;

  // A flushed instruction or an undefined code looks like "no op".
  assign op = (md.req || (md.start > OP_MTLO)) ? OP_NONE : md.start;

  assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div = (op == OP_DIV)  || (op == OP_DIVU);
  assign div0   = (md.b == 32'd0);

`ifdef MDU_DIV0_FAST_EN
  assign div0_skip = is_div && div0;
`else
  assign div0_skip = 1'b0;
`endif

  // Operands widened to 64 bits so the low half of a 64x64 product is the
  // exact 32x32 result for both signed and unsigned forms.
  assign a_sx   = {{32{md.a[31]}}, md.a};
  assign b_sx   = {{32{md.b[31]}}, md.b};
  assign a_zx   = {32'd0, md.a};
  assign b_zx   = {32'd0, md.b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  // A zero divisor is replaced by 1 purely to keep the dividers well defined;
  // the result is discarded at commit via wr_n.
  assign dvs = div0 ? 32'd1 : md.b;

  // 0x80000000 / -1 overflows 32-bit signed division; the MIPS result is
  // quotient 0x80000000, remainder 0, produced here explicitly.
  assign div_ovf = (md.a == 32'h8000_0000) && (dvs == 32'hFFFF_FFFF);

  always_comb begin
    quot_s = 32'd0;
    rem_s  = 32'd0;
    if (div_ovf) begin
      quot_s = 32'h8000_0000;
      rem_s  = 32'd0;
    end else begin
      quot_s = $signed(md.a) / $signed(dvs);
      rem_s  = $signed(md.a) % $signed(dvs);
    end
  end

  assign quot_u = md.a / dvs;
  assign rem_u  = md.a % dvs;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      OP_DIV:   begin res_hi = rem_s;         res_lo = quot_s;       end
      OP_DIVU:  begin res_hi = rem_u;         res_lo = quot_u;       end
      default:  begin res_hi = 32'd0;         res_lo = 32'd0;        end
    endcase
  end

  // Next-state and control decode. Anything arriving during RUN is ignored.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    commit    = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    case (state)
      IDLE: begin
        if ((is_mul || is_div) && !div0_skip) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else if (op == OP_MTHI) begin
          wr_hi = 1'b1;
        end else if (op == OP_MTLO) begin
          wr_lo = 1'b1;
        end
      end
      RUN: begin
        if (cnt == CW'(1)) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi_n  <= '0;
      lo_n  <= '0;
      wr_n  <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_nxt;

      if (load) begin
        cnt  <= is_mul ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
        hi_n <= res_hi;
        lo_n <= res_lo;
        wr_n <= !(is_div && div0);
      end else if (state == RUN) begin
        cnt <= cnt - CW'(1);
      end

      if (commit && wr_n) begin
        hi_q <= hi_n;
        lo_q <= lo_n;
      end
      if (wr_hi) hi_q <= md.a;
      if (wr_lo) lo_q <= md.a;
    end
  end

  // busy is a direct decode of the state flop, so it carries no
  // combinational path from the inputs.
  assign md.busy = (state == RUN);
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

  // MFHI/MFLO read is zero latency from the raw start code.
  always_comb begin
    md.rdata = 32'd0;
    if (md.start == OP_MFHI)      md.rdata = hi_q;
    else if (md.start == OP_MFLO) md.rdata = lo_q;
  end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  localparam int MULN = 5;
  localparam int DIVN = 10;
`ifdef MDU_DIV0_FAST_EN
  localparam int DIV0_BUSY = 0;
`else
  localparam int DIV0_BUSY = DIVN;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_unit_if mdif ();

  md_unit #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mdif)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of an MD op as {hi, lo}, from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r;
    logic [63:0] res;
    res = 64'd0;
    case (op)
      4'd1: begin
        la = longint'($signed(a));
        lb = longint'($signed(b));
        res = la * lb;
      end
      4'd2: res = {32'd0, a} * {32'd0, b};
      4'd3: begin
        la = longint'($signed(a));
        lb = longint'($signed(b));
        q = la / lb;
        r = la % lb;
        res = {r[31:0], q[31:0]};
      end
      4'd4: res = {a % b, a / b};
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // Behavioural model: remaining busy cycles plus pending result.
  int          m_left;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          p_wr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left <= 0;
      m_hi <= 0; m_lo <= 0; p_hi <= 0; p_lo <= 0; p_wr <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1 && p_wr) begin
        m_hi <= p_hi;
        m_lo <= p_lo;
      end
    end else if (!mdif.req) begin
      case (mdif.start)
        4'd1, 4'd2: begin
          {p_hi, p_lo} <= ref_res(mdif.start, mdif.a, mdif.b);
          p_wr <= 1;
          m_left <= MULN;
        end
        4'd3, 4'd4: begin
          if (mdif.b == 0) begin
            p_wr <= 0;
            m_left <= DIV0_BUSY;
          end else begin
            {p_hi, p_lo} <= ref_res(mdif.start, mdif.a, mdif.b);
            p_wr <= 1;
            m_left <= DIVN;
          end
        end
        4'd7: m_hi <= mdif.a;
        4'd8: m_lo <= mdif.a;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", {31'd0, mdif.busy}, {31'd0, (m_left != 0)});
      check("cyc_hi", mdif.hi, m_hi);
      check("cyc_lo", mdif.lo, m_lo);
      check("cyc_rdata", mdif.rdata,
            (mdif.start == 4'd5) ? m_hi : (mdif.start == 4'd6) ? m_lo : 32'd0);
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv, input logic rq);
    @(posedge clk); #1;
    mdif.start = op; mdif.a = av; mdif.b = bv; mdif.req = rq;
    @(posedge clk); #1;
    mdif.start = 4'd0; mdif.req = 1'b0;
  endtask

  task automatic busy_len(input int window, output int n);
    n = 0;
    for (int i = 0; i < window; i++) begin
      @(negedge clk);
      if (mdif.busy) n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2;
    reset = 1'b1;
    mdif.start = 4'd0; mdif.req = 1'b0; mdif.a = 32'd0; mdif.b = 32'd0;
    @(posedge clk);
    chk_en = 1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, mdif.busy}, 32'd0);
    check("rst_hi", mdif.hi, 32'd0);
    check("rst_lo", mdif.lo, 32'd0);

    // signed multiply
    issue(4'd1, 32'hFFFF_FFFD, 32'd5, 1'b0);
    busy_len(MULN + 4, n);
    check("mult_busy", n, 5);
    check("mult_hi", mdif.hi, 32'hFFFF_FFFF);
    check("mult_lo", mdif.lo, 32'hFFFF_FFF1);

    // unsigned multiply
    issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    busy_len(MULN + 4, n);
    check("multu_busy", n, 5);
    check("multu_hi", mdif.hi, 32'h0000_0001);
    check("multu_lo", mdif.lo, 32'hFFFF_FFFE);

    // signed divide
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    busy_len(DIVN + 4, n);
    check("div_busy", n, 10);
    check("div_lo", mdif.lo, 32'hFFFF_FFFD);
    check("div_hi", mdif.hi, 32'hFFFF_FFFF);

    // signed overflow case
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    busy_len(DIVN + 4, n);
    check("divovf_lo", mdif.lo, 32'h8000_0000);
    check("divovf_hi", mdif.hi, 32'd0);

    // preload and divide by zero
    issue(4'd7, 32'h11, 32'd0, 1'b0);
    @(negedge clk);
    check("mthi", mdif.hi, 32'h11);
    issue(4'd8, 32'h22, 32'd0, 1'b0);
    @(negedge clk);
    check("mtlo", mdif.lo, 32'h22);
    issue(4'd4, 32'd1234, 32'd0, 1'b0);
    busy_len(DIVN + 4, n);
    check("div0_busy", n, DIV0_BUSY);
    check("div0_hi", mdif.hi, 32'h11);
    check("div0_lo", mdif.lo, 32'h22);

    // flushed op
    issue(4'd1, 32'd3, 32'd4, 1'b1);
    busy_len(MULN + 2, n);
    check("flush_busy", n, 0);
    check("flush_hi", mdif.hi, 32'h11);
    check("flush_lo", mdif.lo, 32'h22);
    @(posedge clk); #1;
    mdif.start = 4'd6;
    @(negedge clk);
    check("mflo_rdata", mdif.rdata, 32'h22);
    @(posedge clk); #1;
    mdif.start = 4'd5;
    @(negedge clk);
    check("mfhi_rdata", mdif.rdata, 32'h11);
    @(posedge clk); #1;
    mdif.start = 4'd12; mdif.a = 32'hBAD0_0000; mdif.b = 32'd3;
    @(negedge clk);
    check("undef_rdata", mdif.rdata, 32'd0);
    @(posedge clk); #1;
    mdif.start = 4'd0;

    // ops arriving during RUN are ignored
    issue(4'd2, 32'd7, 32'd6, 1'b0);
    n = 0;
    mdif.start = 4'd7; mdif.a = 32'hDEAD_BEEF;
    @(negedge clk); if (mdif.busy) n++;
    @(posedge clk); #1;
    mdif.start = 4'd3; mdif.a = 32'd1; mdif.b = 32'd1;
    @(negedge clk); if (mdif.busy) n++;
    @(posedge clk); #1;
    mdif.start = 4'd0;
    busy_len(MULN + 3, n2);
    check("ign_busy", n + n2, 5);
    check("ign_hi", mdif.hi, 32'd0);
    check("ign_lo", mdif.lo, 32'd42);

    // back-to-back: next op accepted in cycle N+1
    issue(4'd2, 32'd2, 32'd3, 1'b0);
    repeat (MULN) @(posedge clk);
    #1;
    mdif.start = 4'd2; mdif.a = 32'd5; mdif.b = 32'd5;
    @(negedge clk);
    check("b2b_idle", {31'd0, mdif.busy}, 32'd0);
    check("b2b_lo1", mdif.lo, 32'd6);
    @(posedge clk); #1;
    mdif.start = 4'd0;
    @(negedge clk);
    check("b2b_busy", {31'd0, mdif.busy}, 32'd1);
    busy_len(MULN + 3, n);
    check("b2b_rest", n, MULN - 1);
    check("b2b_lo2", mdif.lo, 32'd25);

    // reset in busy cycle 4 of a divide
    issue(4'd7, 32'h55, 32'd0, 1'b0);
    issue(4'd3, 32'd100, 32'd7, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rstmid_busy", {31'd0, mdif.busy}, 32'd0);
    check("rstmid_hi", mdif.hi, 32'd0);
    check("rstmid_lo", mdif.lo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (DIVN + 2) @(negedge clk);
    check("rstpost_busy", {31'd0, mdif.busy}, 32'd0);
    check("rstpost_hi", mdif.hi, 32'd0);
    check("rstpost_lo", mdif.lo, 32'd0);

    @(negedge clk);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
